// File: rtl/elevator_request_scheduler_pkg.sv
// Shared elevator types and sizing, used by the request scheduler and the control block.
package elevator_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 9;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_UP   = 2'd1,
        SERVE_DOWN = 2'd2,
        DWELL      = 2'd3
    } sched_state_t;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Signal bundle between the call-button side, the request scheduler and the elevator control block.
interface elevator_request_scheduler_if #(
    parameter int NUM_FLOORS = elevator_pkg::MAX_FLOORS
);
    logic [NUM_FLOORS-1:0]            call_btn;
    logic [elevator_pkg::FLOOR_W-1:0] Current_floor;
    logic                             Over_weight;
    logic [elevator_pkg::FLOOR_W-1:0] Request_floor;
    logic [NUM_FLOORS-1:0]            pending;
    logic                             Dir_up;
    logic                             Dwell;
    logic                             Idle;

    modport master (
        output call_btn, Current_floor, Over_weight,
        input  Request_floor, pending, Dir_up, Dwell, Idle
    );

    modport slave (
        input  call_btn, Current_floor, Over_weight,
        output Request_floor, pending, Dir_up, Dwell, Idle
    );
endinterface

// File: rtl/elevator_floor_search.sv
// Combinational nearest-call search: lowest pending floor above, highest below, and the current floor's bit.
module elevator_floor_search
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = MAX_FLOORS
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_cur,
    output logic                  o_above_vld,
    output logic [FLOOR_W-1:0]    o_above,
    output logic                  o_below_vld,
    output logic [FLOOR_W-1:0]    o_below,
    output logic                  o_here
);
    always_comb begin
        o_above_vld = 1'b0;
        o_above     = '0;
        o_below_vld = 1'b0;
        o_below     = '0;
        o_here      = 1'b0;
        // Descending scan so the last hit is the lowest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (FLOOR_W'(i) > i_cur)) begin
                o_above_vld = 1'b1;
                o_above     = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i_pending[i] && (FLOOR_W'(i) < i_cur)) begin
                o_below_vld = 1'b1;
                o_below     = FLOOR_W'(i);
            end
            if (FLOOR_W'(i) == i_cur) begin
                o_here = i_pending[i];
            end
        end
    end
endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches floor calls, drives one target floor at a time and
// holds a door-dwell window at each served floor before clearing its call.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = MAX_FLOORS,
    parameter int DWELL_CYCLES = 4
) (
    input logic                          clk,
    input logic                          reset,
    elevator_request_scheduler_if.slave  bus
);
    localparam int               CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

    sched_state_t          r_state, w_state_nxt, w_ev_state, w_sw_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt, w_clr, w_cur_oh, w_call_mask;
    logic [FLOOR_W-1:0]    r_req, w_req_nxt, w_ev_req, w_sw_req;
    logic                  r_dir_up, w_dir_nxt, w_ev_dir, w_sw_dir;
    logic                  r_dwell, w_dwell_nxt, r_idle, w_idle_nxt;
    logic                  w_cur_ok, w_here_call;
    logic                  w_above_vld, w_below_vld, w_here;
    logic [FLOOR_W-1:0]    w_above, w_below, w_cur;

    assign w_cur    = bus.Current_floor;
    assign w_cur_ok = (w_cur < FLOOR_W'(NUM_FLOORS));

    elevator_floor_search #(.NUM_FLOORS(NUM_FLOORS)) u_search (
        .i_pending   (r_pending),
        .i_cur       (w_cur),
        .o_above_vld (w_above_vld),
        .o_above     (w_above),
        .o_below_vld (w_below_vld),
        .o_below     (w_below),
        .o_here      (w_here)
    );

    // A call for the floor being dwelt at extends the dwell instead of being latched.
    always_comb begin
        w_cur_oh = '0;
        if (w_cur_ok) begin
            w_cur_oh = NUM_FLOORS'(1) << w_cur;
        end
        w_call_mask   = (r_state == DWELL) ? ~w_cur_oh : '1;
        w_here_call   = (r_state == DWELL) && (|(bus.call_btn & w_cur_oh));
        w_pending_nxt = (r_pending | (bus.call_btn & w_call_mask)) & ~w_clr;
    end

    // Fresh evaluation from rest (ties go up) and the post-dwell sweep decision.
    always_comb begin
        w_ev_state = IDLE;
        w_ev_req   = w_cur;
        w_ev_dir   = r_dir_up;
        if (w_here) begin
            w_ev_state = DWELL;
        end else if (w_above_vld && (!w_below_vld || ((w_above - w_cur) <= (w_cur - w_below)))) begin
            w_ev_state = SERVE_UP;
            w_ev_req   = w_above;
            w_ev_dir   = 1'b1;
        end else if (w_below_vld) begin
            w_ev_state = SERVE_DOWN;
            w_ev_req   = w_below;
            w_ev_dir   = 1'b0;
        end

        w_sw_state = IDLE;
        w_sw_req   = w_cur;
        w_sw_dir   = r_dir_up;
        if ((r_dir_up && w_above_vld) || (!r_dir_up && !w_below_vld && w_above_vld)) begin
            w_sw_state = SERVE_UP;
            w_sw_req   = w_above;
            w_sw_dir   = 1'b1;
        end else if (w_below_vld) begin
            w_sw_state = SERVE_DOWN;
            w_sw_req   = w_below;
            w_sw_dir   = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_dir_nxt   = r_dir_up;
        w_cnt_nxt   = r_cnt;
        w_clr       = '0;
        if (w_cur_ok) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = w_ev_state;
                    w_req_nxt   = w_ev_req;
                    w_dir_nxt   = w_ev_dir;
                end
                SERVE_UP, SERVE_DOWN: begin
                    if (w_cur == r_req) begin
                        w_state_nxt = DWELL;
                        w_req_nxt   = w_cur;
                    end else if ((r_state == SERVE_UP) && w_above_vld) begin
                        w_req_nxt = w_above;
                    end else if ((r_state == SERVE_DOWN) && w_below_vld) begin
                        w_req_nxt = w_below;
                    end else begin
                        w_state_nxt = w_ev_state;
                        w_req_nxt   = w_ev_req;
                        w_dir_nxt   = w_ev_dir;
                    end
                end
                DWELL: begin
                    w_req_nxt = w_cur;
                    if (w_here_call) begin
                        w_cnt_nxt = CNT_LOAD;
                    end else if (!bus.Over_weight) begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end else begin
                            w_clr       = w_cur_oh;
                            w_state_nxt = w_sw_state;
                            w_req_nxt   = w_sw_req;
                            w_dir_nxt   = w_sw_dir;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
            if ((w_state_nxt == DWELL) && (r_state != DWELL)) begin
                w_cnt_nxt = CNT_LOAD;
            end
        end
    end

    always_comb begin
        w_dwell_nxt = (w_state_nxt == DWELL);
        w_idle_nxt  = (w_state_nxt == IDLE) && (w_pending_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_req     <= '0;
            r_dir_up  <= 1'b1;
            r_dwell   <= 1'b0;
            r_idle    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_req     <= w_req_nxt;
            r_dir_up  <= w_dir_nxt;
            r_dwell   <= w_dwell_nxt;
            r_idle    <= w_idle_nxt;
        end
    end

    assign bus.Request_floor = r_req;
    assign bus.pending       = r_pending;
    assign bus.Dir_up        = r_dir_up;
    assign bus.Dwell         = r_dwell;
    assign bus.Idle          = r_idle;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for the SCAN request scheduler with hand-computed expectations.
module tb_elevator_request_scheduler;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    elevator_request_scheduler_if #(.NUM_FLOORS(9)) bus ();

    elevator_request_scheduler #(
        .NUM_FLOORS   (9),
        .DWELL_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with Dwell high from now until the edge that drops it.
    task automatic run_dwell(input string tag, input int exp_len);
        int n;
        n = 0;
        while (bus.Dwell && (n < 40)) begin
            n++;
            tick();
        end
        chk(tag, n, exp_len);
    endtask

    task automatic press(input logic [8:0] btn);
        bus.call_btn = btn;
        tick();
        bus.call_btn = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.call_btn = '0;
        bus.Current_floor = 4'd0;
        bus.Over_weight = 1'b0;
        #12;
        chk("rst_pending", bus.pending, 9'h000);
        chk("rst_req", bus.Request_floor, 0);
        chk("rst_dir", bus.Dir_up, 1);
        chk("rst_dwell", bus.Dwell, 0);
        chk("rst_idle", bus.Idle, 1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single call to floor 5 from floor 0
        press(9'h020);
        chk("t1_pending", bus.pending, 9'h020);
        chk("t1_req_early", bus.Request_floor, 0);
        chk("t1_idle_low", bus.Idle, 0);
        tick();
        chk("t1_req", bus.Request_floor, 5);
        chk("t1_dir", bus.Dir_up, 1);
        bus.Current_floor = 4'd5;
        tick();
        chk("t1_dwell_on", bus.Dwell, 1);
        run_dwell("t1_dwell_len", 4);
        chk("t1_pending_clr", bus.pending, 9'h000);
        chk("t1_idle", bus.Idle, 1);

        // Floor 4, calls 2 and 6 together: tie goes up
        bus.Current_floor = 4'd4;
        press(9'h044);
        tick();
        chk("t2_req_up", bus.Request_floor, 6);
        chk("t2_dir_up", bus.Dir_up, 1);
        bus.Current_floor = 4'd6;
        tick();
        run_dwell("t2_dwell6", 4);
        chk("t2_req_down", bus.Request_floor, 2);
        chk("t2_dir_down", bus.Dir_up, 0);
        chk("t2_pending", bus.pending, 9'h004);
        bus.Current_floor = 4'd2;
        tick();
        run_dwell("t2_dwell2", 4);
        chk("t2_pending_clr", bus.pending, 9'h000);
        chk("t2_dir_hold", bus.Dir_up, 0);

        // En-route pickup: heading to 8 from 1, call at 3
        bus.Current_floor = 4'd1;
        press(9'h100);
        tick();
        chk("t3_req8", bus.Request_floor, 8);
        press(9'h008);
        tick();
        chk("t3_req3", bus.Request_floor, 3);
        bus.Current_floor = 4'd3;
        tick();
        run_dwell("t3_dwell3", 4);
        chk("t3_req8_again", bus.Request_floor, 8);
        chk("t3_pending", bus.pending, 9'h100);
        bus.Current_floor = 4'd8;
        tick();
        run_dwell("t3_dwell8", 4);
        chk("t3_pending_clr", bus.pending, 9'h000);

        // Over_weight freezes the dwell counter for 3 cycles
        press(9'h040);
        tick();
        chk("t4_req6", bus.Request_floor, 6);
        chk("t4_dir", bus.Dir_up, 0);
        bus.Current_floor = 4'd6;
        tick();
        bus.Over_weight = 1'b1;
        tick();
        tick();
        tick();
        bus.Over_weight = 1'b0;
        chk("t4_dwell_held", bus.Dwell, 1);
        chk("t4_pending_held", bus.pending, 9'h040);
        run_dwell("t4_dwell_rest", 4);
        chk("t4_pending_clr", bus.pending, 9'h000);

        // Current-floor call during dwell reloads the counter
        press(9'h080);
        tick();
        chk("t5_req7", bus.Request_floor, 7);
        bus.Current_floor = 4'd7;
        tick();
        tick();
        chk("t5_dwell_mid", bus.Dwell, 1);
        press(9'h080);
        run_dwell("t5_dwell_reload", 4);
        chk("t5_pending_clr", bus.pending, 9'h000);

        // Out-of-range Current_floor: FSM holds, calls still latch
        bus.Current_floor = 4'd15;
        press(9'h001);
        tick();
        chk("t6_pending", bus.pending, 9'h001);
        chk("t6_req_hold", bus.Request_floor, 7);
        chk("t6_dwell", bus.Dwell, 0);
        chk("t6_idle", bus.Idle, 0);
        bus.Current_floor = 4'd0;
        tick();
        run_dwell("t6_dwell0", 4);
        chk("t6_pending_clr", bus.pending, 9'h000);

        // Asynchronous reset mid-SERVE_DOWN
        bus.Current_floor = 4'd8;
        press(9'h0FF);
        tick();
        chk("t7_req7", bus.Request_floor, 7);
        press(9'h1FF);
        chk("t7_pending_all", bus.pending, 9'h1FF);
        chk("t7_dir", bus.Dir_up, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_rst_pending", bus.pending, 9'h000);
        chk("t7_rst_req", bus.Request_floor, 0);
        chk("t7_rst_dir", bus.Dir_up, 1);
        chk("t7_rst_dwell", bus.Dwell, 0);
        chk("t7_rst_idle", bus.Idle, 1);
        tick();
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Collects floor calls and presents one target floor at a time on `Request_floor` to the elevator control block, using the up/down sweep (SCAN) policy. It reads back that block's `Current_floor` and `Over_weight`. It holds a door-dwell window at each served floor and clears the call only when the dwell completes. The block sits directly upstream of the elevator control block.

## Interface
- `NUM_FLOORS`, default 9: floors 0..NUM_FLOORS-1; must be ≤ 9 so every target is < 4'b1001.
- `DWELL_CYCLES`, default 4: door-open cycles per served floor; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `call_btn` in NUM_FLOORS: merged car/hall call buttons, one bit per floor; pulse or level.
- `Current_floor` in 4: floor reported by the control block.
- `Over_weight` in 1: overload flag shared with the control block.
- `Request_floor` out 4: target floor driven to the control block.
- `pending` out NUM_FLOORS: latched outstanding calls.
- `Dir_up` out 1: sweep direction (1 = up, 0 = down).
- `Dwell` out 1: high while the door-dwell window is active.
- `Idle` out 1: high when no calls are pending and the FSM is in IDLE.

## Operation
- Call latching:
  - `pending[i] <= pending[i] | call_btn[i]` every cycle.
  - Exception: a call for `Current_floor` while in DWELL is not latched. Instead it reloads the dwell counter.
- FSM states: IDLE, SERVE_UP, SERVE_DOWN, DWELL.
- Nearest-floor search over `pending`:
  - `above` = lowest pending floor greater than `Current_floor`.
  - `below` = highest pending floor less than `Current_floor`.
  - `here` = `pending[Current_floor]`.
- IDLE:
  - `Request_floor` = `Current_floor`.
  - If `here`, go to DWELL.
  - Else if `above` exists and its distance ≤ distance to `below` (ties go up), go to SERVE_UP.
  - Else if `below` exists, go to SERVE_DOWN.
- SERVE_UP:
  - `Request_floor` = `above`, re-evaluated every cycle, so a nearer new call is taken en route.
  - If `Current_floor == Request_floor`, go to DWELL.
  - If `above` vanishes, fall back to the IDLE evaluation in the same cycle.
- SERVE_DOWN: mirror of SERVE_UP using `below`.
- DWELL:
  - `Request_floor` = `Current_floor`; `Dwell` = 1.
  - The counter loads `DWELL_CYCLES-1` on entry and decrements each cycle.
  - `Over_weight = 1` freezes the counter.
  - When the counter is 0 and `Over_weight = 0`:
    - Clear `pending[Current_floor]`.
    - Continue in the same direction if calls remain that way; else reverse; else go to IDLE.
- `Dir_up` updates on entry to SERVE_UP (1) or SERVE_DOWN (0). It holds its value in IDLE and DWELL.
- `Current_floor ≥ NUM_FLOORS`: state, counter and `Request_floor` hold. Calls are still latched.
- `Request_floor` never exceeds `NUM_FLOORS-1`.

## Timing
- All outputs are registered.
- Reset values: `pending` = 0, state IDLE, `Request_floor` = 0, `Dir_up` = 1, `Dwell` = 0, `Idle` = 1, counter = 0.
- Reset asserted mid-operation discards all pending calls immediately (asynchronously).
- Call latency:
  - `call_btn` sampled at edge t → `pending` set after edge t.
  - `Request_floor` and state reflect the call after edge t+1.
- Arrival: `Current_floor == Request_floor` sampled at edge t → `Dwell` = 1 after edge t.
- Dwell length: exactly `DWELL_CYCLES` cycles plus one cycle per cycle of `Over_weight` high.
- The pending bit clears, and the next target drives, on the same edge that drops `Dwell`.
- A call and its clear never collide: a current-floor call during DWELL reloads the counter (see Operation).

## Structure
- Shared package `elevator_pkg` holds:
  - `FLOOR_W` = 4 and `MAX_FLOORS` = 9.
  - The state enum `sched_state_t` {IDLE, SERVE_UP, SERVE_DOWN, DWELL}.
  - This package is shared with the control block.
- Sub-module `elevator_floor_search` is combinational. It takes `pending` and `Current_floor` and returns `above_vld/above`, `below_vld/below` and `here`.
- The top level holds the FSM, the dwell counter and the pending register.

## Test plan
- Reset, `Current_floor` = 0, `call_btn[5]` pulse:
  - `pending` = 9'h020; `Request_floor` = 5 two edges later; `Dir_up` = 1.
  - `Current_floor` stepped to 5 → `Dwell` high for 4 cycles → `pending` = 0, `Idle` = 1.
- At floor 4, calls 2 and 6 pressed in the same cycle: the tie goes up, so 6 is served first, then 2, with `Dir_up` 1 then 0.
- SERVE_UP toward 8 from floor 1, call 3 pressed → `Request_floor` switches to 3 next cycle; 8 is served after the dwell at 3.
- `Over_weight` high for 3 cycles during dwell → `Dwell` lasts 7 cycles; `pending` bit held until the counter reaches 0.
- Current-floor call during DWELL → counter reloads, dwell extends to 4 cycles from the press, and the bit is never set.
- Async reset mid-SERVE_DOWN with `pending` = 9'h1FF → all outputs take reset values immediately, with no clock edge needed.
